// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush squash and saturating debug counters.
// One cycle ID->EX; stall_o is combinational and holds PC/IF/ID for exactly one cycle while a bubble is loaded.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [2:0]       id_alu_ctrl,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             id_reg_write,
  input  logic             id_alu_src,
  input  logic             id_branch,
  input  logic             ex_flush,
  output logic             stall_o,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_alu_ctrl,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_reg_write,
  output logic             ex_alu_src,
  output logic             ex_branch,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      alu_ctrl;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            reg_write;
    logic            alu_src;
    logic            branch;
  } ex_reg_t;

  logic [6:0]       id_opcode;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       id_rd;
  logic             uses_rs1;
  logic             uses_rs2;
  logic             load_use;
  logic             unused_instr_bits;
  ex_reg_t          id_cap;
  ex_reg_t          ex_d;
  ex_reg_t          ex_q;
  logic [CNT_W-1:0] bubble_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;

  assign id_opcode = id_instr[6:0];
  assign id_rd     = id_instr[11:7];
  assign id_rs1    = id_instr[19:15];
  assign id_rs2    = id_instr[24:20];
  assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:12]};

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (id_opcode)
      OP_R, OP_STORE, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  // A load into x0 never forwards anything, so it cannot create a hazard.
  assign load_use = ex_q.vld & ex_q.mem_read & (ex_q.rd != 5'd0) & id_valid &
                    ((uses_rs1 & (ex_q.rd == id_rs1)) | (uses_rs2 & (ex_q.rd == id_rs2)));
  assign stall_o  = load_use & ~ex_flush;

  always_comb begin
    id_cap            = '0;
    id_cap.vld        = id_valid;
    id_cap.pc         = id_pc;
    id_cap.rs1_data   = id_rs1_data;
    id_cap.rs2_data   = id_rs2_data;
    id_cap.imm        = id_imm;
    id_cap.rs1        = id_rs1;
    id_cap.rs2        = id_rs2;
    id_cap.rd         = id_rd;
    id_cap.alu_ctrl   = id_alu_ctrl;
    id_cap.mem_read   = id_mem_read;
    id_cap.mem_to_reg = id_mem_to_reg;
    id_cap.alu_src    = id_alu_src;
    // Architecturally visible side effects are killed for an invalid slot.
    id_cap.mem_write  = id_mem_write & id_valid;
    id_cap.reg_write  = id_reg_write & id_valid;
    id_cap.branch     = id_branch & id_valid;

    ex_d         = id_cap;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    if (ex_flush) begin
      ex_d = '0;
      if (id_valid && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end else if (load_use) begin
      ex_d = '0;
      if (bubble_cnt_q != '1) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign ex_valid      = ex_q.vld;
  assign ex_pc         = ex_q.pc;
  assign ex_rs1_data   = ex_q.rs1_data;
  assign ex_rs2_data   = ex_q.rs2_data;
  assign ex_imm        = ex_q.imm;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_rd         = ex_q.rd;
  assign ex_alu_ctrl   = ex_q.alu_ctrl;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_branch     = ex_q.branch;
  assign bubble_cnt    = bubble_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX contents are queued as each ID slot is driven and checked after the edge.
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 10;

  localparam logic [31:0] ADD_X3_X1_X2 = 32'h002081B3;
  localparam logic [31:0] LW_X5_X1     = 32'h0000A283;
  localparam logic [31:0] ADD_X6_X5_X2 = 32'h00228333;
  localparam logic [31:0] ADDI_X6_X7_5 = 32'h00538313;
  localparam logic [31:0] LW_X0_X1     = 32'h0000A003;
  localparam logic [31:0] ADD_X6_X0_X0 = 32'h00000333;
  localparam logic [31:0] SW_X2_X1     = 32'h0020A023;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  alu;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        rw;
    logic        as;
    logic        br;
  } ex_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [31:0]      id_instr;
  logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [2:0]       id_alu_ctrl;
  logic             id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write, id_alu_src, id_branch;
  logic             ex_flush;
  logic             stall_o, ex_valid;
  logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic [2:0]       ex_alu_ctrl;
  logic             ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_alu_src, ex_branch;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;

  int               total = 0;
  int               bad = 0;
  int               exp_bub = 0;
  int               exp_flush = 0;
  ex_t              sb_q[$];
  bit               sb_bub_q[$];
  ex_t              obs, exp_e;
  bit               is_bub;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_ctrl(id_alu_ctrl), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write), .id_alu_src(id_alu_src),
    .id_branch(id_branch), .ex_flush(ex_flush), .stall_o(stall_o), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write(ex_reg_write), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decoder stand-in: control bits per opcode, random datapath values.
  task automatic decode(input logic v, input logic [31:0] instr);
    id_valid = v; id_instr = instr;
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_alu_ctrl = 3'b000; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    id_reg_write = 0; id_alu_src = 0; id_branch = 0;
    case (instr[6:0])
      7'b0110011: begin id_alu_ctrl = 3'b010; id_reg_write = 1; end
      7'b0010011: begin id_alu_ctrl = 3'b010; id_reg_write = 1; id_alu_src = 1; end
      7'b0000011: begin id_alu_ctrl = 3'b010; id_reg_write = 1; id_alu_src = 1; id_mem_read = 1; id_mem_to_reg = 1; end
      7'b0100011: begin id_alu_ctrl = 3'b010; id_alu_src = 1; id_mem_write = 1; end
      7'b1100011: begin id_alu_ctrl = 3'b110; id_branch = 1; end
      default: ;
    endcase
    #1;
  endtask

  function automatic ex_t cap_exp();
    ex_t e;
    e.vld = id_valid; e.pc = id_pc; e.rs1d = id_rs1_data; e.rs2d = id_rs2_data; e.imm = id_imm;
    e.rs1 = id_instr[19:15]; e.rs2 = id_instr[24:20]; e.rd = id_instr[11:7];
    e.alu = id_alu_ctrl; e.mr = id_mem_read; e.m2r = id_mem_to_reg; e.as = id_alu_src;
    e.mw = id_mem_write & id_valid; e.rw = id_reg_write & id_valid; e.br = id_branch & id_valid;
    return e;
  endfunction

  // Bubble datapath fields other than rd are don't-care, so they are masked.
  function automatic ex_t get_obs(input bit mask_dp);
    ex_t o;
    o = '{ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_alu_ctrl,
          ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_alu_src, ex_branch};
    if (mask_dp) begin
      o.pc = '0; o.rs1d = '0; o.rs2d = '0; o.imm = '0; o.rs1 = '0; o.rs2 = '0;
    end
    return o;
  endfunction

  function automatic int sat_inc(input int v);
    return (v == (1 << CNT_W) - 1) ? v : v + 1;
  endfunction

  task automatic push_cap();
    sb_q.push_back(cap_exp()); sb_bub_q.push_back(1'b0);
  endtask

  task automatic push_bub();
    sb_q.push_back('0); sb_bub_q.push_back(1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1; ex_flush = 0;
    decode(0, 32'h0);
    tick();
    #2 rst_n = 0;
    #1;
    total++; if (get_obs(0) !== '0) begin bad++; $display("FAIL reset_ex_state got %h want 0", get_obs(0)); end
    total++; if ({bubble_cnt, flush_cnt} !== '0) begin bad++; $display("FAIL reset_counters got %h/%h want 0/0", bubble_cnt, flush_cnt); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got %b want 0", stall_o); end
    @(posedge clk);
    #3 rst_n = 1;
    exp_bub = 0; exp_flush = 0;
    sb_q.delete(); sb_bub_q.delete();
    push_cap();
    tick();
    exp_e = sb_q.pop_front(); is_bub = sb_bub_q.pop_front(); obs = get_obs(is_bub);
    total++; if (obs !== exp_e) begin bad++; $display("FAIL reset_release_idle got %h want %h", obs, exp_e); end
  endtask

  task automatic test_passthrough();
    decode(1, ADD_X3_X1_X2);
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL pass_stall got %b want 0", stall_o); end
    push_cap();
    tick();
    exp_e = sb_q.pop_front(); is_bub = sb_bub_q.pop_front(); obs = get_obs(is_bub);
    total++; if (obs !== exp_e) begin bad++; $display("FAIL pass_ex_state got %h want %h", obs, exp_e); end
    total++;
    if ({ex_valid, ex_rd, ex_reg_write, ex_alu_ctrl} !== {1'b1, 5'd3, 1'b1, 3'b010}) begin
      bad++; $display("FAIL pass_add_fields got v=%b rd=%0d rw=%b alu=%b want 1/3/1/010", ex_valid, ex_rd, ex_reg_write, ex_alu_ctrl);
    end
  endtask

  task automatic test_load_use();
    decode(1, LW_X5_X1);
    push_cap();
    tick();
    exp_e = sb_q.pop_front(); is_bub = sb_bub_q.pop_front(); obs = get_obs(is_bub);
    total++; if (obs !== exp_e) begin bad++; $display("FAIL lu_load_capture got %h want %h", obs, exp_e); end
    decode(1, ADD_X6_X5_X2);
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL lu_stall_raised got %b want 1", stall_o); end
    push_bub();
    exp_bub = sat_inc(exp_bub);
    tick();
    exp_e = sb_q.pop_front(); is_bub = sb_bub_q.pop_front(); obs = get_obs(is_bub);
    total++; if (obs !== exp_e) begin bad++; $display("FAIL lu_bubble got %h want %h", obs, exp_e); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL lu_stall_one_cycle got %b want 0", stall_o); end
    total++; if (bubble_cnt !== CNT_W'(exp_bub)) begin bad++; $display("FAIL lu_bubble_cnt got %0d want %0d", bubble_cnt, exp_bub); end
    push_cap();
    tick();
    exp_e = sb_q.pop_front(); is_bub = sb_bub_q.pop_front(); obs = get_obs(is_bub);
    total++; if (obs !== exp_e) begin bad++; $display("FAIL lu_add_enters got %h want %h", obs, exp_e); end
    total++; if (ex_rs1 !== 5'd5) begin bad++; $display("FAIL lu_add_rs1 got %0d want 5", ex_rs1); end
  endtask

  task automatic test_no_false_stall();
    logic [31:0] seq [4];
    seq[0] = LW_X5_X1; seq[1] = ADDI_X6_X7_5; seq[2] = LW_X0_X1; seq[3] = ADD_X6_X0_X0;
    for (int i = 0; i < 4; i++) begin
      decode(1, seq[i]);
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL nofalse_stall[%0d] got %b want 0", i, stall_o); end
      push_cap();
      tick();
      exp_e = sb_q.pop_front(); is_bub = sb_bub_q.pop_front(); obs = get_obs(is_bub);
      total++; if (obs !== exp_e) begin bad++; $display("FAIL nofalse_capture[%0d] got %h want %h", i, obs, exp_e); end
    end
    total++; if (bubble_cnt !== CNT_W'(exp_bub)) begin bad++; $display("FAIL nofalse_bubble_cnt got %0d want %0d", bubble_cnt, exp_bub); end
  endtask

  task automatic test_flush();
    decode(1, SW_X2_X1);
    ex_flush = 1; #1;
    push_bub();
    exp_flush = sat_inc(exp_flush);
    tick();
    decode(0, SW_X2_X1);
    exp_e = sb_q.pop_front(); is_bub = sb_bub_q.pop_front(); obs = get_obs(is_bub);
    total++; if (obs !== exp_e) begin bad++; $display("FAIL flush_bubble got %h want %h", obs, exp_e); end
    total++; if (ex_mem_write !== 1'b0) begin bad++; $display("FAIL flush_mem_write got %b want 0", ex_mem_write); end
    total++; if (flush_cnt !== CNT_W'(exp_flush)) begin bad++; $display("FAIL flush_cnt got %0d want %0d", flush_cnt, exp_flush); end
    push_bub();
    tick();
    ex_flush = 0;
    exp_e = sb_q.pop_front(); is_bub = sb_bub_q.pop_front(); obs = get_obs(is_bub);
    total++; if (obs !== exp_e) begin bad++; $display("FAIL flush_invalid_bubble got %h want %h", obs, exp_e); end
    total++; if (flush_cnt !== CNT_W'(exp_flush)) begin bad++; $display("FAIL flush_invalid_cnt got %0d want %0d", flush_cnt, exp_flush); end
  endtask

  task automatic test_flush_beats_stall();
    decode(1, LW_X5_X1);
    push_cap();
    tick();
    exp_e = sb_q.pop_front(); is_bub = sb_bub_q.pop_front(); obs = get_obs(is_bub);
    total++; if (obs !== exp_e) begin bad++; $display("FAIL fbs_load got %h want %h", obs, exp_e); end
    decode(1, ADD_X6_X5_X2);
    ex_flush = 1; #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL fbs_stall got %b want 0", stall_o); end
    push_bub();
    exp_flush = sat_inc(exp_flush);
    tick();
    ex_flush = 0;
    exp_e = sb_q.pop_front(); is_bub = sb_bub_q.pop_front(); obs = get_obs(is_bub);
    total++; if (obs !== exp_e) begin bad++; $display("FAIL fbs_bubble got %h want %h", obs, exp_e); end
    total++;
    if ({bubble_cnt, flush_cnt} !== {CNT_W'(exp_bub), CNT_W'(exp_flush)}) begin
      bad++; $display("FAIL fbs_counters got %0d/%0d want %0d/%0d", bubble_cnt, flush_cnt, exp_bub, exp_flush);
    end
  endtask

  task automatic test_invalid_slot();
    logic [31:0] seq [3];
    seq[0] = SW_X2_X1; seq[1] = 32'h00000063; seq[2] = LW_X5_X1;
    for (int i = 0; i < 3; i++) begin
      decode(0, seq[i]);
      push_cap();
      tick();
      exp_e = sb_q.pop_front(); is_bub = sb_bub_q.pop_front(); obs = get_obs(is_bub);
      total++; if (obs !== exp_e) begin bad++; $display("FAIL invalid_capture[%0d] got %h want %h", i, obs, exp_e); end
    end
    // An invalid load sitting in EX must not stall a dependent consumer.
    decode(1, ADD_X6_X5_X2);
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL invalid_load_stall got %b want 0", stall_o); end
    push_cap();
    tick();
    exp_e = sb_q.pop_front(); is_bub = sb_bub_q.pop_front(); obs = get_obs(is_bub);
    total++; if (obs !== exp_e) begin bad++; $display("FAIL invalid_load_consumer got %h want %h", obs, exp_e); end
  endtask

  task automatic test_reset_mid_stall();
    decode(1, LW_X5_X1);
    tick();
    decode(1, ADD_X6_X5_X2);
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL rms_stall_before got %b want 1", stall_o); end
    rst_n = 0; #1;
    exp_bub = 0; exp_flush = 0;
    total++; if ({stall_o, ex_valid} !== 2'b00) begin bad++; $display("FAIL rms_dropped got stall=%b v=%b want 0/0", stall_o, ex_valid); end
    total++; if ({bubble_cnt, flush_cnt} !== '0) begin bad++; $display("FAIL rms_counters got %0d/%0d want 0/0", bubble_cnt, flush_cnt); end
    @(posedge clk);
    #3 rst_n = 1;
    push_cap();
    tick();
    exp_e = sb_q.pop_front(); is_bub = sb_bub_q.pop_front(); obs = get_obs(is_bub);
    total++; if (obs !== exp_e) begin bad++; $display("FAIL rms_first_capture got %h want %h", obs, exp_e); end
  endtask

  task automatic test_saturation();
    int n_stall = (1 << CNT_W) + 5;
    int missed = 0;
    for (int i = 0; i < n_stall; i++) begin
      decode(1, LW_X5_X1);
      tick();
      decode(1, ADD_X6_X5_X2);
      if (stall_o !== 1'b1) missed++;
      exp_bub = sat_inc(exp_bub);
      tick();
    end
    total++; if (missed !== 0) begin bad++; $display("FAIL sat_stalls_missed got %0d want 0", missed); end
    total++; if (bubble_cnt !== CNT_W'(exp_bub)) begin bad++; $display("FAIL sat_bubble_cnt got %h want %h", bubble_cnt, CNT_W'(exp_bub)); end
    total++; if (bubble_cnt !== {CNT_W{1'b1}}) begin bad++; $display("FAIL sat_holds_max got %h want all ones", bubble_cnt); end
    total++; if (flush_cnt !== CNT_W'(exp_flush)) begin bad++; $display("FAIL sat_flush_cnt got %0d want %0d", flush_cnt, exp_flush); end
  endtask

  initial begin
    rst_n = 0; ex_flush = 0;
    decode(0, 32'h0);
    test_reset();
    test_passthrough();
    test_load_use();
    test_no_false_stall();
    test_flush();
    test_flush_beats_stall();
    test_invalid_slot();
    test_reset_mid_stall();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
